// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 style fetch/sequencing controller.
package lc3_ctrl_pkg;

    typedef enum logic [3:0] {
        StHalted,
        StFetch1,
        StFetch2,
        StFetch3,
        StDecode,
        StBrTake,
        StJmp,
        StJsrSave,
        StJsrLoad,
        StPause
    } state_e;

    localparam logic [3:0] OpBr  = 4'h0;
    localparam logic [3:0] OpJmp = 4'hC;
    localparam logic [3:0] OpJsr = 4'h4;

    localparam logic [1:0] PcSelInc   = 2'b00;
    localparam logic [1:0] PcSelBus   = 2'b01;
    localparam logic [1:0] PcSelAdder = 2'b10;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Controller <-> datapath bundle: decoded IR fields and memory status in, load/gate strobes out.
interface fetch_ctrl_if;

    logic [3:0] opcode;
    logic [2:0] ir_nzp;
    logic [2:0] cc_nzp;
    logic       mem_rdy;
    logic       ld_pc;
    logic [1:0] pcmux_sel;
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       mem_oe;
    logic       gate_pc;

    modport master (
        input  opcode, ir_nzp, cc_nzp, mem_rdy,
        output ld_pc, pcmux_sel, ld_mar, ld_mdr, ld_ir, mem_oe, gate_pc
    );

    modport slave (
        output opcode, ir_nzp, cc_nzp, mem_rdy,
        input  ld_pc, pcmux_sel, ld_mar, ld_mdr, ld_ir, mem_oe, gate_pc
    );

endinterface

// File: rtl/br_eval.sv
// Branch-condition test: taken when any requested condition code is currently set.
module br_eval (
    input  logic [2:0] ir_nzp,
    input  logic [2:0] cc_nzp,
    output logic       taken
);

    assign taken = |(ir_nzp & cc_nzp);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch / sequencing FSM. Define FETCH_MEM_WAIT_EN to make FETCH2 wait on mem_rdy
// instead of using a fixed two-cycle read.
module fetch_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter logic [3:0] PAUSE_OP = 4'hD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               continue_i,
    fetch_ctrl_if.master       bus,
    output logic               exec_pulse,
    output logic [15:0]        instr_count
);

    state_e      state_q, state_d;
    logic [15:0] instr_count_q;
    logic        cnt_inc;
    logic        br_taken;
    logic        f2_done;
    logic        is_exec;

    br_eval u_br_eval (
        .ir_nzp (bus.ir_nzp),
        .cc_nzp (bus.cc_nzp),
        .taken  (br_taken)
    );

`ifdef FETCH_MEM_WAIT_EN
    assign f2_done = bus.mem_rdy;
`else
    logic f2_cnt_q;
    logic unused_mem_rdy;

    assign unused_mem_rdy = bus.mem_rdy;
    assign f2_done        = f2_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f2_cnt_q <= 1'b0;
        end else begin
            f2_cnt_q <= (state_q == StFetch2) ? ~f2_cnt_q : 1'b0;
        end
    end
`endif

    assign is_exec = (bus.opcode != OpBr) && (bus.opcode != OpJmp) &&
                     (bus.opcode != OpJsr) && (bus.opcode != PAUSE_OP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StHalted;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalted:  if (run) state_d = StFetch1;
            StFetch1:  state_d = StFetch2;
            StFetch2:  if (f2_done) state_d = StFetch3;
            StFetch3:  state_d = StDecode;
            StDecode: begin
                // run is only honoured here so a fetch in flight always completes
                if (bus.opcode == OpBr) begin
                    if (br_taken) state_d = StBrTake;
                    else          state_d = run ? StFetch1 : StHalted;
                end else if (bus.opcode == OpJmp) begin
                    state_d = StJmp;
                end else if (bus.opcode == OpJsr) begin
                    state_d = StJsrSave;
                end else if (bus.opcode == PAUSE_OP) begin
                    state_d = StPause;
                end else begin
                    state_d = run ? StFetch1 : StHalted;
                end
            end
            StBrTake:  state_d = StFetch1;
            StJmp:     state_d = StFetch1;
            StJsrSave: state_d = StJsrLoad;
            StJsrLoad: state_d = StFetch1;
            StPause:   if (continue_i) state_d = StFetch1;
            default:   state_d = StHalted;
        endcase
    end

    always_comb begin
        bus.ld_pc     = 1'b0;
        bus.pcmux_sel = PcSelInc;
        bus.ld_mar    = 1'b0;
        bus.ld_mdr    = 1'b0;
        bus.ld_ir     = 1'b0;
        bus.mem_oe    = 1'b0;
        bus.gate_pc   = 1'b0;
        exec_pulse    = 1'b0;
        unique case (state_q)
            StFetch1: begin
                bus.gate_pc = 1'b1;
                bus.ld_mar  = 1'b1;
                bus.ld_pc   = 1'b1;
            end
            StFetch2: begin
                bus.mem_oe = 1'b1;
                bus.ld_mdr = f2_done;
            end
            StFetch3:  bus.ld_ir = 1'b1;
            StDecode:  exec_pulse = is_exec;
            StBrTake: begin
                bus.ld_pc     = 1'b1;
                bus.pcmux_sel = PcSelAdder;
            end
            StJmp: begin
                bus.ld_pc     = 1'b1;
                bus.pcmux_sel = PcSelBus;
            end
            StJsrSave: bus.gate_pc = 1'b1;
            StJsrLoad: begin
                bus.ld_pc     = 1'b1;
                bus.pcmux_sel = PcSelAdder;
            end
            default: ;
        endcase
    end

    // Retirement is any re-entry to FETCH1 other than the first one out of HALTED.
    assign cnt_inc = (state_d == StFetch1) && (state_q != StHalted) && (state_q != StFetch1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count_q <= 16'h0000;
        end else if (cnt_inc) begin
            instr_count_q <= instr_count_q + 16'h0001;
        end
    end

    assign instr_count = instr_count_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter PAUSE_OP, default 4'hD, giving the opcode that halts sequencing until continue_i.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port run, input, 1, a level that starts sequencing from HALTED.
REQ-005 The block SHALL have port continue_i, input, 1, a level that releases PAUSE.
REQ-006 The block SHALL have port opcode, input, 4, IR[15:12] once the IR has been loaded.
REQ-007 The block SHALL have port ir_nzp, input, 3, IR[11:9] branch condition.
REQ-008 The block SHALL have port cc_nzp, input, 3, the current condition codes.
REQ-009 The block SHALL have port mem_rdy, input, 1, read-data-valid from memory.
REQ-010 The block SHALL have port ld_pc, output, 1, the PC load enable.
REQ-011 The block SHALL have port pcmux_sel, output, 2, the PC source: 00 = PC+1, 01 = bus data, 10 = address adder.
REQ-012 The block SHALL have ports ld_mar, ld_mdr, ld_ir, mem_oe and gate_pc, each output, 1, the datapath load and gate strobes.
REQ-013 The block SHALL have port exec_pulse, output, 1, a one-cycle strobe handing a non-control instruction to the execute unit.
REQ-014 The block SHALL have port instr_count, output, 16, the number of retired instructions.

Function
REQ-015 The block SHALL be a Moore FSM with states HALTED, FETCH1, FETCH2, FETCH3, DECODE, BR_TAKE, JMP, JSR_SAVE, JSR_LOAD and PAUSE.
REQ-016 HALTED SHALL move to FETCH1 when run=1 and otherwise hold with all strobes 0.
REQ-017 FETCH1 SHALL assert gate_pc, ld_mar and ld_pc with pcmux_sel=00, so MAR<=PC and PC<=PC+1 in one cycle, and SHALL then move to FETCH2.
REQ-018 FETCH2 SHALL assert mem_oe and ld_mdr, and SHALL leave for FETCH3 per REQ-032/033.
REQ-019 FETCH3 SHALL assert ld_ir and SHALL then move to DECODE.
REQ-020 DECODE SHALL branch on opcode: 0000 to BR_TAKE if (ir_nzp & cc_nzp) != 0 and otherwise to FETCH1; 1100 to JMP; 0100 to JSR_SAVE; PAUSE_OP to PAUSE; any other opcode SHALL assert exec_pulse for exactly one cycle and move to FETCH1.
REQ-021 BR_TAKE SHALL assert ld_pc with pcmux_sel=10 and SHALL then move to FETCH1.
REQ-022 JMP SHALL assert ld_pc with pcmux_sel=01 and SHALL then move to FETCH1.
REQ-023 JSR_SAVE (R7 save, gate_pc=1) SHALL be followed by JSR_LOAD, which SHALL assert ld_pc with pcmux_sel=10 and then move to FETCH1.
REQ-024 PAUSE SHALL hold until continue_i=1, then move to FETCH1.
REQ-025 In every state not named above as asserting ld_pc, ld_pc SHALL be 0 and pcmux_sel SHALL be 00.
REQ-026 instr_count SHALL increment by 1 on every transition into FETCH1 from DECODE, BR_TAKE, JMP, JSR_LOAD or PAUSE, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-027 Deasserting run SHALL be sampled only in DECODE, moving the FSM to HALTED in place of FETCH1, so an instruction is never abandoned mid-fetch.
REQ-028 An opcode value SHALL be used only in DECODE; it SHALL be ignored in every other state.

Reset
REQ-029 reset=0 SHALL, asynchronously and in any state including mid-fetch, force the state to HALTED, instr_count to 0 and all strobes to 0.
REQ-030 Release of reset SHALL be synchronous to clk; the first transition SHALL occur on the first rising edge of clk after release.

Configuration
REQ-031 The design SHALL compile conditionally on the macro FETCH_MEM_WAIT_EN.
REQ-032 With FETCH_MEM_WAIT_EN defined, FETCH2 SHALL hold until mem_rdy=1, asserting ld_mdr only in the mem_rdy cycle, and SHALL then move to FETCH3.
REQ-033 With FETCH_MEM_WAIT_EN undefined, mem_rdy SHALL be ignored and FETCH2 SHALL last exactly 2 cycles using an internal 1-bit counter, with ld_mdr asserted in the second cycle.

Structure
REQ-034 The package lc3_ctrl_pkg SHALL hold the state enum, the opcode constants (BR, JMP, JSR) and the pcmux_sel encodings.
REQ-035 The branch-condition test SHALL be a combinational sub-module named br_eval, returning (ir_nzp & cc_nzp) != 0.

Verification
REQ-036 Reset and run: reset=0 then 1, run=1 -> HALTED, then FETCH1 on the next edge; the fetch strobes follow REQ-017 to REQ-019 on the following edges.
REQ-037 Branch taken and not taken: opcode=0000 with ir_nzp=010 and cc_nzp=010 -> BR_TAKE with pcmux_sel=10 and ld_pc=1; with cc_nzp=100 -> FETCH1 and no ld_pc.
REQ-038 JSR: opcode=0100 -> JSR_SAVE (gate_pc=1), then JSR_LOAD (pcmux_sel=10), then FETCH1; instr_count increments by 1.
REQ-039 Pause: opcode=4'hD with continue_i held 0 for 5 cycles -> the FSM stays in PAUSE; continue_i=1 -> FETCH1.
REQ-040 Memory wait (FETCH_MEM_WAIT_EN defined): mem_rdy held 0 for 3 cycles -> the FSM stays in FETCH2 with ld_mdr=0; mem_rdy=1 -> ld_mdr=1, then FETCH3.
REQ-041 Wrap and reset mid-operation: preload instr_count to 16'hFFFF and retire one instruction -> 16'h0000; assert reset=0 in FETCH2 -> HALTED and all strobes 0 immediately, without a clock edge.
